// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the timer array
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage

// File: rtl/timer_array_if.sv
// rtl/timer_array_if.sv - word-addressed register window plus irq vector
interface timer_array_if #(
  parameter int AW   = 3,
  parameter int N_CH = 2
);
  logic [AW-1:0]   addr;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [N_CH-1:0] irq;

  modport master (output addr, output we, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: registers, FSM, sticky pend (TIMER_PRESCALE_EN adds a prescaler)
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_we,
  input  logic        preset_we,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] preset_rd,
  output logic [31:0] count_rd,
  output logic        irq
);

  state_t           state, state_nxt;
  logic             en, en_nxt, im, pend;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset, count;
  logic             tick, dec;
  logic [7:0]       ps_field;
  logic             unused_wdata;

  // Only the low CTRL bits and the low CNT_W PRESET bits are stored.
  assign unused_wdata = ^wdata;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] ps, ps_cnt;
  assign tick     = (ps_cnt == ps);
  assign ps_field = ps;

  // prescale divider: restarts in IDLE/LOAD, holds outside CNT otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      ps     <= '0;
      ps_cnt <= '0;
    end else begin
      if (ctrl_we) ps <= wdata[CTRL_PS_LO +: 8];
      if (state == IDLE || state == LOAD) ps_cnt <= '0;
      else if (state == CNT) ps_cnt <= tick ? '0 : ps_cnt + 8'd1;
    end
  end
`else
  assign tick     = 1'b1;
  assign ps_field = '0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: a cleared enable (CPU or one-shot completion) always lands in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_nxt) state_nxt = LOAD;
      LOAD:    state_nxt = CNT;
      CNT:     if (tick && count <= CNT_W'(1)) state_nxt = INT;
      INT:     state_nxt = (mode == MODE_AUTO) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!en_nxt) state_nxt = IDLE;
  end

  // outputs: resolved enable (CPU write beats one-shot clear), decrement strobe, irq
  always_comb begin
    en_nxt = en;
    if (state == INT && mode != MODE_AUTO) en_nxt = 1'b0;
    if (ctrl_we) en_nxt = wdata[CTRL_EN];
    dec = (state == CNT) && en_nxt && tick;
    irq = im & pend;
  end

  // control/preset/count registers and sticky pend (INT set beats CTRL clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
    end else begin
      en <= en_nxt;
      if (ctrl_we) begin
        mode <= wdata[CTRL_MODE_LO +: 2];
        im   <= wdata[CTRL_IM];
      end
      if (preset_we) preset <= wdata[CNT_W-1:0];
      if (state == LOAD) count <= preset;
      else if (dec) count <= (count <= CNT_W'(1)) ? '0 : count - CNT_W'(1);
      if (state == INT) pend <= 1'b1;
      else if (ctrl_we) pend <= 1'b0;
    end
  end

  assign ctrl_rd   = {20'b0, ps_field, im, mode, en};
  assign preset_rd = 32'(preset);
  assign count_rd  = 32'(count);

endmodule

// File: rtl/timer_array.sv
// rtl/timer_array.sv - N-channel interval timer top: decode and read mux (TIMER_PRESCALE_EN passes to channels)
module timer_array
  import timer_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          reset,
  timer_array_if.slave bus
);

  localparam int AW = $clog2(N_CH) + 2;

  logic [AW-1:0]   ch_sel;
  logic [1:0]      reg_sel;
  logic [31:0]     ctrl_rd   [N_CH];
  logic [31:0]     preset_rd [N_CH];
  logic [31:0]     count_rd  [N_CH];
  logic [N_CH-1:0] irq;

  assign ch_sel  = bus.addr >> 2;
  assign reg_sel = bus.addr[1:0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (bus.we && (ch_sel == AW'(i)) && (reg_sel == REG_CTRL)),
      .preset_we (bus.we && (ch_sel == AW'(i)) && (reg_sel == REG_PRESET)),
      .wdata     (bus.wdata),
      .ctrl_rd   (ctrl_rd[i]),
      .preset_rd (preset_rd[i]),
      .count_rd  (count_rd[i]),
      .irq       (irq[i])
    );
  end

  assign bus.irq = irq;

  // read mux: unpopulated channels and the reserved slot read as zero
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_CTRL:   bus.rdata = ctrl_rd[i];
          REG_PRESET: bus.rdata = preset_rd[i];
          REG_COUNT:  bus.rdata = count_rd[i];
          default:    bus.rdata = '0;
        endcase
      end
    end
  end

endmodule
